// File: rtl/vrf_pkg.sv
// Shared types and default sizing for the vector register file and the
// issue/writeback stages that connect to it.
package vrf_pkg;

  // Clear sequencer states
  typedef enum logic [0:0] {
    VRF_IDLE  = 1'b0,
    VRF_CLEAR = 1'b1
  } vrf_state_t;

  // Default geometry used by the issue and writeback stages
  localparam int VRF_DATA_WIDTH   = 64;
  localparam int VRF_COL_WIDTH    = 8;
  localparam int VRF_ADDR_WIDTH   = 5;
  localparam int VRF_NUM_RD       = 2;
  localparam int VRF_CLEAR_ON_RST = 1;

  // Number of byte-enable columns in one entry
  function automatic int num_cols(input int dataWidth, input int colWidth);
    return dataWidth / colWidth;
  endfunction

endpackage

// File: rtl/vrf_clr_ctrl.sv
// Clear sequencer: walks every entry once, emitting an all-zero write per
// cycle, and reports busy while the walk is in progress.
module vrf_clr_ctrl
  import vrf_pkg::*;
#(
  parameter int ADDR_WIDTH   = VRF_ADDR_WIDTH,
  parameter int CLEAR_ON_RST = VRF_CLEAR_ON_RST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  vrf_state_t            stateReg;
  logic [ADDR_WIDTH-1:0] cntReg;

  // FSM and address counter; a request arriving mid-clear is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      cntReg <= '0;
      if (CLEAR_ON_RST != 0) stateReg <= VRF_CLEAR;
      else                   stateReg <= VRF_IDLE;
    end else begin
      case (stateReg)
        VRF_IDLE: begin
          cntReg <= '0;
          if (clr_req) stateReg <= VRF_CLEAR;
        end
        VRF_CLEAR: begin
          cntReg <= cntReg + ADDR_WIDTH'(1);
          if (cntReg == LAST_ADDR) stateReg <= VRF_IDLE;
        end
        default: begin
          cntReg   <= '0;
          stateReg <= VRF_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from the state register; no writes during reset
  assign busy     = (stateReg == VRF_CLEAR);
  assign clr_we   = busy & ~rst;
  assign clr_addr = cntReg;

endmodule

// File: rtl/vrf_bank_mp.sv
// Multi-read-port vector register bank with byte-enabled write, write-first
// bypass on collision and a built-in clear sequencer.
module vrf_bank_mp
  import vrf_pkg::*;
#(
  parameter int DATA_WIDTH   = VRF_DATA_WIDTH,
  parameter int COL_WIDTH    = VRF_COL_WIDTH,
  parameter int ADDR_WIDTH   = VRF_ADDR_WIDTH,
  parameter int NUM_RD       = VRF_NUM_RD,
  parameter int CLEAR_ON_RST = VRF_CLEAR_ON_RST
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_req,
  output logic                           busy,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH/COL_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid
);

  localparam int NCOLS = num_cols(DATA_WIDTH, COL_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] memArray [DEPTH];

  logic                  clrWe;
  logic [ADDR_WIDTH-1:0] clrAddr;
  logic                  userWe;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [NCOLS-1:0]      memBe;
  logic [DATA_WIDTH-1:0] memData;

  vrf_clr_ctrl #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) uClrCtrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clrWe),
    .clr_addr (clrAddr)
  );

  // User writes are only honoured when the bank is idle and out of reset
  assign userWe = wr_en & ~busy & ~rst;

  // Clear write takes over the single physical write port while busy
  always_comb begin
    memWe   = userWe;
    memAddr = wr_addr;
    memBe   = wr_be;
    memData = wr_data;
    if (clrWe) begin
      memWe   = 1'b1;
      memAddr = clrAddr;
      memBe   = '1;
      memData = '0;
    end
  end

  // Byte-enabled array write
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int c = 0; c < NCOLS; c++) begin
        if (memBe[c]) memArray[memAddr][c*COL_WIDTH +: COL_WIDTH] <= memData[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : gRd
    logic [ADDR_WIDTH-1:0] portAddr;
    logic                  hit;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic [DATA_WIDTH-1:0] rdDataReg;
    logic                  rdValidReg;

    assign portAddr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit      = userWe && (wr_addr == portAddr);

    // Write-first merge: enabled columns of a colliding write win
    always_comb begin
      mergedWord = memArray[portAddr];
      for (int c = 0; c < NCOLS; c++) begin
        if (hit && wr_be[c]) mergedWord[c*COL_WIDTH +: COL_WIDTH] = wr_data[c*COL_WIDTH +: COL_WIDTH];
      end
    end

    // Registered read; data holds whenever no read is accepted
    always_ff @(posedge clk) begin
      if (rst) begin
        rdDataReg  <= '0;
        rdValidReg <= 1'b0;
      end else if (busy) begin
        rdValidReg <= 1'b0;
      end else begin
        rdValidReg <= rd_en[gi];
        if (rd_en[gi]) rdDataReg <= mergedWord;
      end
    end

    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = rdDataReg;
    assign rd_valid[gi]                         = rdValidReg;
  end

endmodule

// File: tb/tb_vrf_bank_mp.sv
// Scoreboard bench for vrf_bank_mp: stimulus pushes expected read words,
// a monitor pops and compares whenever a port presents rd_valid.
module tb_vrf_bank_mp;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NC = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_req;
  logic              busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NC-1:0]     wr_be;
  logic [DW-1:0]     wr_data;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_valid;

  logic              busyNc;
  logic [NR*DW-1:0]  rdDataNc;
  logic [NR-1:0]     rdValidNc;

  vrf_bank_mp #(.DATA_WIDTH(DW), .COL_WIDTH(8), .ADDR_WIDTH(AW), .NUM_RD(NR), .CLEAR_ON_RST(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  vrf_bank_mp #(.DATA_WIDTH(DW), .COL_WIDTH(8), .ADDR_WIDTH(AW), .NUM_RD(NR), .CLEAR_ON_RST(0)) dutNc (
    .clk(clk), .rst(rst), .clr_req(1'b0), .busy(busyNc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdDataNc), .rd_valid(rdValidNc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] d;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void pushExp(input int p, input logic [63:0] d);
    exp_t e;
    e.d   = d;
    e.due = cyc + 1;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic exp_t popExp(input int p);
    if (p == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic exp_t peekExp(input int p);
    if (p == 0) return q0[0];
    return q1[0];
  endfunction

  // Monitor: compare each presented read against the scoreboard
  task automatic monCheck(input int p);
    exp_t        e;
    int          sz;
    logic        v;
    logic [63:0] d;
    sz = (p == 0) ? q0.size() : q1.size();
    v  = rd_valid[p];
    d  = rd_data[p*DW +: DW];
    if (v) begin
      if (sz == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid p%0d: got valid with data %h, required no valid", p, d);
      end else begin
        e = popExp(p);
        chk($sformatf("rd_data p%0d", p), d, e.d);
        chk($sformatf("rd_latency p%0d", p), 64'(cyc), 64'(e.due));
      end
    end else if (sz > 0) begin
      e = peekExp(p);
      if (e.due <= cyc) begin
        e = popExp(p);
        total++;
        bad++;
        $display("FAIL missing_valid p%0d: got no valid at cycle %0d, required data %h", p, cyc, e.d);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int p = 0; p < NR; p++) monCheck(p);
    end
  end

  // One cycle of stimulus, applied at a negedge and held until the next
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [NC-1:0] be,
                      input logic [DW-1:0] wd, input logic [NR-1:0] re,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {ra1, ra0};
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = '0;
  endtask

  // Counts negedges with busy high; optionally hammers the ports meanwhile
  task automatic measureBusy(input bit junk, output int n);
    n = 0;
    while (busy && n < 200) begin
      if (junk) begin
        wr_en   = 1'b1;
        wr_addr = AW'(n);
        wr_be   = '1;
        wr_data = {2{32'hDEADBEEF}};
        rd_en   = '1;
        rd_addr = {AW'(31 - n), AW'(n)};
        clr_req = (n == 5);
      end
      @(negedge clk);
      n++;
    end
    wr_en   = 1'b0;
    rd_en   = '0;
    clr_req = 1'b0;
  endtask

  task automatic fillAll(input logic [31:0] tag);
    for (int i = 0; i < 32; i++) step(1'b1, AW'(i), 8'hFF, {tag, 32'(i + 1)}, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic readAllZero();
    for (int i = 0; i < 32; i++) begin
      pushExp(0, 64'h0);
      pushExp(1, 64'h0);
      step(1'b0, 5'd0, 8'h00, 64'h0, 2'b11, AW'(i), AW'(31 - i));
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0;
    wr_data = '0; rd_en = '0; rd_addr = '0;

    // Reset state and initial clear
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rd_valid", 64'(rd_valid), 64'h0);
    chk("reset rd_data p0", rd_data[63:0], 64'h0);
    chk("reset rd_data p1", rd_data[127:64], 64'h0);
    chk("reset busy clear_on_rst=1", 64'(busy), 64'h1);
    chk("reset busy clear_on_rst=0", 64'(busyNc), 64'h0);
    chk("reset rd_valid clear_on_rst=0", 64'(rdValidNc), 64'h0);
    chk("reset rd_data clear_on_rst=0", rdDataNc[63:0], 64'h0);
    rst = 1'b0;
    measureBusy(1'b0, n);
    chk("reset clear busy cycles", 64'(n), 64'd32);

    // Every entry reads zero after the reset clear
    for (int i = 0; i < 32; i++) begin
      pushExp(0, 64'h0);
      step(1'b0, 5'd0, 8'h00, 64'h0, 2'b01, AW'(i), 5'd0);
    end

    // Byte-enable write merge
    step(1'b1, 5'd5, 8'hFF, 64'h1122334455667788, 2'b00, 5'd0, 5'd0);
    step(1'b1, 5'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 2'b00, 5'd0, 5'd0);
    pushExp(0, 64'h11223344AAAAAAAA);
    step(1'b0, 5'd0, 8'h00, 64'h0, 2'b01, 5'd5, 5'd0);

    // Write-first bypass on both ports, then the stored result
    pushExp(0, 64'hFFFFFFFF00000000);
    pushExp(1, 64'hFFFFFFFF00000000);
    step(1'b1, 5'd7, 8'hF0, 64'hFFFFFFFFFFFFFFFF, 2'b11, 5'd7, 5'd7);
    pushExp(0, 64'hFFFFFFFF00000000);
    pushExp(1, 64'hFFFFFFFF00000000);
    step(1'b0, 5'd0, 8'h00, 64'h0, 2'b11, 5'd7, 5'd7);

    // Independent ports and hold on an idle port
    step(1'b1, 5'd1, 8'hFF, 64'h1, 2'b00, 5'd0, 5'd0);
    step(1'b1, 5'd2, 8'hFF, 64'h2, 2'b00, 5'd0, 5'd0);
    pushExp(0, 64'h1);
    pushExp(1, 64'h2);
    step(1'b0, 5'd0, 8'h00, 64'h0, 2'b11, 5'd1, 5'd2);
    pushExp(0, 64'h1);
    step(1'b0, 5'd0, 8'h00, 64'h0, 2'b01, 5'd1, 5'd2);
    chk("partial rd_valid", 64'(rd_valid), 64'h1);
    chk("idle port1 hold", rd_data[127:64], 64'h2);

    // Clear request with blocked traffic and a repeated request
    fillAll(32'hC0DE0000);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    measureBusy(1'b1, n);
    chk("clr_req busy cycles", 64'(n), 64'd32);
    readAllZero();

    // Reset in the middle of a clear restarts the sequence
    fillAll(32'hBEEF0000);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-clear reset busy clear_on_rst=0", 64'(busyNc), 64'h0);
    measureBusy(1'b0, n);
    chk("mid-clear reset busy cycles", 64'(n), 64'd32);
    readAllZero();

    repeat (4) @(negedge clk);
    chk("scoreboard p0 drained", 64'(q0.size()), 64'h0);
    chk("scoreboard p1 drained", 64'(q1.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vrf_bank_mp.md
Name: vrf_bank_mp

Overview:
Parametrised multi-read-port vector register bank for the vector unit. It provides:
- one byte-enabled write port;
- NUM_RD independent registered read ports;
- write-first bypass on address collision;
- a built-in clear sequencer that zeroes every entry after reset or on request.

It sits between the issue stage (reads operands) and the writeback stage (writes results), replacing the earlier fixed-width RAM wrappers.

Parameters:
DATA_WIDTH, 64, bits per entry; must be a multiple of COL_WIDTH.
COL_WIDTH, 8, bits per byte-enable column.
ADDR_WIDTH, 5, entry address bits; depth = 2**ADDR_WIDTH.
NUM_RD, 2, number of read ports, 1..4.
CLEAR_ON_RST, 1, 1 = run the clear sequence after reset; 0 = skip it.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr_req  in  1  pulse: start a clear sequence
busy  out  1  clear sequence in progress
wr_en  in  1  write strobe
wr_addr  in  ADDR_WIDTH  write address
wr_be  in  DATA_WIDTH/COL_WIDTH  per-column write enable
wr_data  in  DATA_WIDTH  write data
rd_en  in  NUM_RD  per-port read strobe
rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port p uses slice p
rd_data  out  NUM_RD*DATA_WIDTH  packed registered read data
rd_valid  out  NUM_RD  rd_data slice p is valid this cycle

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: rd_data=0, rd_valid=0, clear counter=0.
  - State resets to CLEAR if CLEAR_ON_RST=1, else IDLE; busy follows state.
  - Array contents are not reset by rst.
- While rst is high, no array writes occur and the counter holds at 0.
- FSM states:
  - IDLE, busy=0: clr_req=1 -> CLEAR next cycle, counter=0.
  - CLEAR, busy=1:
    - Each cycle, write all-zero to entry[counter] and increment the counter.
    - The cycle that writes entry 2**ADDR_WIDTH-1 transitions to IDLE.
    - The clear therefore takes exactly 2**ADDR_WIDTH cycles.
  - clr_req while in CLEAR is ignored; it does not restart the sequence.
  - rst asserted mid-clear restarts per the reset rules.
- While busy=1:
  - wr_en and rd_en are ignored.
  - rd_valid=0 and rd_data holds its last value.
- Write (busy=0, wr_en=1): for each column c with wr_be[c]=1, the entry column takes wr_data column c at the clock edge. Columns with wr_be[c]=0 are unchanged. wr_be=0 is a no-op.
- Read (busy=0): port p with rd_en[p]=1 samples rd_addr slice p.
  - rd_data slice p and rd_valid[p]=1 appear the next cycle (latency 1).
  - rd_en[p]=0 -> rd_valid[p]=0 next cycle; rd_data slice p holds.
- Bypass: a same-cycle read and write to the same address returns the merged word.
  - Columns with wr_be=1 come from wr_data; other columns come from stored data (write-first).
  - Applies independently and identically to every port.
- Multiple ports may read the same address in the same cycle; each receives identical data.
- A read of the last address in the same cycle that CLEAR finishes is ignored, because busy is still 1.

Decomposition:
- Package vrf_pkg holds:
  - the FSM enum, vrf_state_t {VRF_IDLE, VRF_CLEAR};
  - the function num_cols(DATA_WIDTH, COL_WIDTH);
  - a default-parameter localparam set shared with the issue/writeback stages.
- Sub-module vrf_clr_ctrl, the natural split, contains:
  - inputs: clk, rst, clr_req;
  - outputs: busy, clr_we, clr_addr;
  - the FSM and counter.
- The top level muxes the clear write over the user write port.

Test Plan:
All scenarios use the default parameters (32 entries, 8 columns, 2 read ports).
- Reset-clear: hold rst 3 cycles, then release -> busy=1 for exactly 32 cycles. Next, read all 32 addresses on port 0 -> every rd_data=0, rd_valid=1 one cycle after each rd_en.
- Byte-enable write:
  - write addr 5, data 0x1122334455667788, wr_be=0xFF;
  - then write addr 5, data 0xAAAAAAAAAAAAAAAA, wr_be=0x0F;
  - read addr 5 -> 0x11223344AAAAAAAA.
- Bypass collision: entry 7 holds 0x0; in one cycle wr addr 7, data 0xFFFFFFFFFFFFFFFF, wr_be=0xF0, with port0 and port1 both reading addr 7 -> both return 0xFFFFFFFF00000000 next cycle.
- Independent ports: port0 reads addr 1 and port1 reads addr 2 in the same cycle (contents 0x1 and 0x2) -> slices return 0x1 and 0x2. With rd_en=2'b01 the next cycle -> rd_valid=2'b01 and port1 data holds 0x2.
- Clear request and blocking:
  - pulse clr_req with nonzero contents, and assert wr_en and rd_en during busy;
  - required: busy is 32 cycles, rd_valid stays 0, the writes are dropped, all entries read 0 afterwards;
  - a second clr_req mid-clear does not extend busy.
- Reset mid-clear: assert rst at clear cycle 10 for 1 cycle -> counter restarts at 0 and busy lasts 32 more cycles. With CLEAR_ON_RST=0 -> busy=0 immediately after reset.
